// File: rtl/dvi_lane_gearbox_if.sv
// Symbol handshake between the TMDS encoder (master) and the lane gearbox (slave).
interface dvi_lane_gearbox_if;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym_in, output sym_valid, input sym_ready);
    modport slave  (input sym_in, input sym_valid, output sym_ready);
endinterface

// File: rtl/dvi_lane_gearbox.sv
// Per-lane 10:2 TMDS gearbox in the 5x pixel clock domain: one rise/fall bit pair per cycle,
// LSB first, with a one-symbol hold buffer and idle substitution on underrun.
module dvi_lane_gearbox #(
    parameter logic [9:0] IDLE_SYMBOL = 10'b1101010100
) (
    input  logic                      clk_x5,
    input  logic                      rst_n_x5,
    dvi_lane_gearbox_if.slave         sym,
    input  logic                      force_idle,
    input  logic                      underrun_clr,
    output logic                      d_rise,
    output logic                      d_fall,
    output logic                      phase0,
    output logic                      underrun,
    output logic                      underrun_sticky
);

    localparam logic [2:0] PhaseFirst = 3'd0;
    localparam logic [2:0] PhaseLoad  = 3'd4;

    logic [9:0] sr_q, sr_d;
    logic [9:0] hold_q, hold_d;
    logic [2:0] phase_q, phase_d;
    logic       hold_full_q, hold_full_d;
    logic       underrun_q, underrun_d;
    logic       sticky_q, sticky_d;
    logic       phase0_q, phase0_d;
    logic       is_load, load_take, accept;

    assign is_load       = (phase_q == PhaseLoad);
    assign load_take     = is_load & ~force_idle & hold_full_q;
    assign sym.sym_ready = ~hold_full_q | load_take;
    assign accept        = sym.sym_valid & sym.sym_ready;

    always_comb begin
        phase_d    = is_load ? PhaseFirst : phase_q + 3'd1;
        // phase0 is registered so the pad-facing outputs all come straight from flops
        phase0_d   = is_load;
        sr_d       = {2'b00, sr_q[9:2]};
        underrun_d = 1'b0;
        if (is_load) begin
            if (force_idle) begin
                sr_d = IDLE_SYMBOL;
            end else if (hold_full_q) begin
                sr_d = hold_q;
            end else begin
                sr_d       = IDLE_SYMBOL;
                underrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        hold_full_d = hold_full_q;
        if (load_take) hold_full_d = 1'b0;
        // A refill in the load cycle keeps the buffer full for back-to-back streaming
        if (accept) hold_full_d = 1'b1;
        hold_d   = accept ? sym.sym_in : hold_q;
        sticky_d = underrun_d ? 1'b1 : (underrun_clr ? 1'b0 : sticky_q);
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            sr_q        <= IDLE_SYMBOL;
            phase_q     <= PhaseFirst;
            phase0_q    <= 1'b1;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            phase_q     <= phase_d;
            phase0_q    <= phase0_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            sticky_q    <= sticky_d;
        end
    end

    // Buffer contents are meaningless while hold_full is low, so no reset is needed
    always_ff @(posedge clk_x5) begin
        hold_q <= hold_d;
    end

    assign d_rise          = sr_q[0];
    assign d_fall          = sr_q[1];
    assign phase0          = phase0_q;
    assign underrun        = underrun_q;
    assign underrun_sticky = sticky_q;

endmodule

// File: tb/tb_dvi_lane_gearbox.sv
// Bench for dvi_lane_gearbox: a monitor reassembles output symbols and checks them against a
// queue of expected symbols filled by the stimulus; directed checks cover reset, force and sticky.
module tb_dvi_lane_gearbox;

    localparam logic [9:0] IDLE = 10'b1101010100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_idle = 1'b0;
    logic underrun_clr = 1'b0;
    logic d_rise, d_fall, phase0, underrun, underrun_sticky;

    dvi_lane_gearbox_if sym_bus ();

    dvi_lane_gearbox dut (
        .clk_x5          (clk),
        .rst_n_x5        (rst_n),
        .sym             (sym_bus),
        .force_idle      (force_idle),
        .underrun_clr    (underrun_clr),
        .d_rise          (d_rise),
        .d_fall          (d_fall),
        .phase0          (phase0),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    // Monitor state: ph is the phase of the cycle being sampled (bench-derived, not read back)
    int         ph = 0;
    int         nsym = 0;
    int         ur_seen = 0;
    logic       ur0 = 1'b0;
    logic [9:0] got = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ph      = 0;
            nsym    = 0;
            ur_seen = 0;
        end else begin
            if (ph == 0) ur0 = underrun;
            if (underrun) ur_seen++;
            check("phase0", {31'd0, phase0}, {31'd0, ph == 0});
            got[2*ph]   = d_rise;
            got[2*ph+1] = d_fall;
            if (ph == 4) begin
                // Symbol 0 after reset is the reset-loaded idle, not part of any stream
                if (nsym > 0) begin
                    if (ur0) begin
                        check("sb_idle", {22'd0, got}, {22'd0, IDLE});
                    end else begin
                        check("sb_avail", {31'd0, exp_q.size() > 0}, 32'd1);
                        if (exp_q.size() > 0) check("sb_data", {22'd0, got}, {22'd0, exp_q.pop_front()});
                    end
                end
                nsym++;
            end
            ph = (ph == 4) ? 0 : ph + 1;
        end
    end

    task automatic apply_reset();
        rst_n             = 1'b0;
        sym_bus.sym_valid = 1'b0;
        sym_bus.sym_in    = '0;
        force_idle        = 1'b0;
        underrun_clr      = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ph != p && n < 20);
        check("wait_phase", ph, p);
    endtask

    task automatic wait_sym(input int n);
        int c = 0;
        while (nsym < n && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("wait_sym", {31'd0, nsym >= n}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] stream [3];
        logic [9:0] next_sym;
        logic       acc;
        int         idx;
        int         c;
        stream[0] = 10'h3FF;
        stream[1] = 10'h000;
        stream[2] = 10'h155;

        // Reset state and idle stream with underruns
        apply_reset();
        #1;
        check("rst_rise", {31'd0, d_rise}, 32'd0);
        check("rst_fall", {31'd0, d_fall}, 32'd0);
        check("rst_phase0", {31'd0, phase0}, 32'd1);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_sticky", {31'd0, underrun_sticky}, 32'd0);
        check("rst_ready", {31'd0, sym_bus.sym_ready}, 32'd1);
        wait_sym(3);
        check("idle_ur_count", ur_seen, 2);
        check("idle_sticky", {31'd0, underrun_sticky}, 32'd1);

        // Sticky clear in a quiet cycle, then clear coincident with an underrun load
        wait_phase(1);
        underrun_clr = 1'b1;
        wait_phase(2);
        underrun_clr = 1'b0;
        check("sticky_clr", {31'd0, underrun_sticky}, 32'd0);
        wait_phase(4);
        underrun_clr = 1'b1;
        @(posedge clk);
        #1 underrun_clr = 1'b0;
        check("sticky_set_wins", {31'd0, underrun_sticky}, 32'd1);
        check("ur_pulse", {31'd0, underrun}, 32'd1);

        // Back-to-back stream
        apply_reset();
        idx = 0;
        c = 0;
        while (idx < 3 && c < 40) begin
            sym_bus.sym_valid = 1'b1;
            sym_bus.sym_in    = stream[idx];
            @(negedge clk);
            acc = sym_bus.sym_valid & sym_bus.sym_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(stream[idx]);
                idx++;
            end
            c++;
        end
        sym_bus.sym_valid = 1'b0;
        check("b2b_accepts", idx, 3);
        wait_sym(4);
        check("b2b_no_underrun", ur_seen, 0);
        check("b2b_drained", exp_q.size(), 0);

        // Random valid, incrementing symbols
        apply_reset();
        next_sym = 10'h001;
        for (int i = 0; i < 400; i++) begin
            sym_bus.sym_valid = 1'($urandom_range(0, 1));
            sym_bus.sym_in    = next_sym;
            @(negedge clk);
            acc = sym_bus.sym_valid & sym_bus.sym_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                exp_q.push_back(next_sym);
                next_sym = next_sym + 10'd1;
            end
        end
        sym_bus.sym_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rand_drained", exp_q.size(), 0);
        check("rand_progress", {31'd0, next_sym > 10'd20}, 32'd1);

        // Forced idle over two loads with a symbol held
        apply_reset();
        force_idle        = 1'b1;
        sym_bus.sym_valid = 1'b1;
        sym_bus.sym_in    = 10'h0F0;
        exp_q.push_back(IDLE);
        exp_q.push_back(IDLE);
        exp_q.push_back(10'h0F0);
        @(posedge clk);
        #1 sym_bus.sym_valid = 1'b0;
        wait_phase(4);
        check("force_ready0", {31'd0, sym_bus.sym_ready}, 32'd0);
        wait_phase(4);
        check("force_ready1", {31'd0, sym_bus.sym_ready}, 32'd0);
        @(posedge clk);
        #1 force_idle = 1'b0;
        wait_sym(4);
        check("force_no_underrun", ur_seen, 0);
        check("force_drained", exp_q.size(), 0);

        // Reset mid-symbol with the buffer full
        apply_reset();
        sym_bus.sym_valid = 1'b1;
        sym_bus.sym_in    = 10'h2AB;
        @(posedge clk);
        #1 sym_bus.sym_valid = 1'b0;
        wait_phase(2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rise", {31'd0, d_rise}, 32'd0);
        check("mid_rst_fall", {31'd0, d_fall}, 32'd0);
        check("mid_rst_phase0", {31'd0, phase0}, 32'd1);
        check("mid_rst_ready", {31'd0, sym_bus.sym_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_sym(3);
        check("mid_rst_ur_count", ur_seen, 2);
        check("mid_rst_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
